// File: rtl/pe_pkg.sv
// pe_pkg: shared constants and arithmetic helpers for the output-stationary PE.
// ext_val widens a w-bit value to 64 bits (sign or zero); add_clamp adds two
// w-bit values and optionally clamps to the w-bit signed/unsigned range.
package pe_pkg;

  localparam int unsigned PE_DW_DEF = 8;
  localparam int unsigned PE_AW_DEF = 32;
  // Helpers work on a 64-bit carrier, so AW must stay below 63 to keep the
  // intermediate sum free of overflow.
  localparam int unsigned PE_MAXW   = 62;

  function automatic logic [63:0] ext_val(input logic [63:0] v,
                                          input int unsigned w,
                                          input bit sgn);
    logic [63:0] m;
    m = v << (64 - w);
    if (sgn) ext_val = $unsigned($signed(m) >>> (64 - w));
    else     ext_val = m >> (64 - w);
  endfunction

  function automatic logic [63:0] add_clamp(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input int unsigned w,
                                            input bit sgn,
                                            input bit sat);
    logic signed [63:0] ax;
    logic signed [63:0] bx;
    logic signed [63:0] s;
    logic signed [63:0] mx;
    logic signed [63:0] mn;
    ax = $signed(ext_val(a, w, sgn));
    bx = $signed(ext_val(b, w, sgn));
    s  = ax + bx;
    if (sat) begin
      if (sgn) begin
        mx = (64'sd1 <<< (w - 1)) - 64'sd1;
        mn = -(64'sd1 <<< (w - 1));
      end else begin
        mx = (64'sd1 <<< w) - 64'sd1;
        mn = 64'sd0;
      end
      if (s > mx)      s = mx;
      else if (s < mn) s = mn;
    end
    add_clamp = $unsigned(s);
  endfunction

endpackage

// File: rtl/pe_drain_slot.sv
// pe_drain_slot: one-entry result register on the drain chain.
// Ports: ld_i/ld_dat_i load (wins over pop, so a same-cycle pop+load replaces
// the entry), pop_i empties it; vld_o/dat_o hold steady until popped.
module pe_drain_slot
  import pe_pkg::*;
#(
  parameter int unsigned W = PE_AW_DEF
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         ld_i,
  input  logic [W-1:0] ld_dat_i,
  input  logic         pop_i,
  output logic         vld_o,
  output logic [W-1:0] dat_o
);

  logic         vld_q, vld_d;
  logic [W-1:0] dat_q, dat_d;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (ld_i) begin
      vld_d = 1'b1;
      dat_d = ld_dat_i;
    end else if (pop_i) begin
      // Clear data too so an idle drain port reads zero.
      vld_d = 1'b0;
      dat_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign vld_o = vld_q;
  assign dat_o = dat_q;

endmodule

// File: rtl/pe_os_mac.sv
// pe_os_mac: output-stationary MAC processing element with a per-column
// result drain chain. Operands (in_fire/in_last/in_a/in_w) are forwarded
// east/south one cycle later (out_*). A last beat closes the dot product into
// the own slot; upstream results (drain_in*) park in the fwd slot; res/res_vld/
// res_rdy present own first, then fwd. ovr flags an own result lost to
// overwrite. Define PE_SAT_EN to clamp accumulation instead of wrapping.
module pe_os_mac
  import pe_pkg::*;
#(
  parameter int unsigned DW     = PE_DW_DEF,
  parameter int unsigned AW     = PE_AW_DEF,
  parameter int unsigned SIGNED = 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_fire,
  input  logic          in_last,
  input  logic [DW-1:0] in_a,
  input  logic [DW-1:0] in_w,
  output logic          out_fire,
  output logic          out_last,
  output logic [DW-1:0] out_a,
  output logic [DW-1:0] out_w,
  input  logic          drain_in_vld,
  input  logic [AW-1:0] drain_in,
  output logic          drain_in_rdy,
  output logic          res_vld,
  output logic [AW-1:0] res,
  input  logic          res_rdy,
  output logic          ovr
);

  localparam bit SGN = (SIGNED != 0);
`ifdef PE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  // Operand forwarding registers.
  logic          out_fire_q, out_last_q;
  logic [DW-1:0] out_a_q, out_w_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_fire_q <= 1'b0;
      out_last_q <= 1'b0;
      out_a_q    <= '0;
      out_w_q    <= '0;
    end else begin
      out_fire_q <= in_fire;
      out_last_q <= in_fire & in_last;
      if (in_fire) begin
        out_a_q <= in_a;
        out_w_q <= in_w;
      end
    end
  end

  assign out_fire = out_fire_q;
  assign out_last = out_last_q;
  assign out_a    = out_a_q;
  assign out_w    = out_w_q;

  // Full-width product: extending operands to 2*DW first makes the low 2*DW
  // bits of a plain multiply correct for both signed and unsigned modes.
  logic [2*DW-1:0] a_x, w_x, prod_raw;
  logic [AW-1:0]   prod_ext;

  assign a_x      = {{DW{SGN & in_a[DW-1]}}, in_a};
  assign w_x      = {{DW{SGN & in_w[DW-1]}}, in_w};
  assign prod_raw = a_x * w_x;
  assign prod_ext = AW'(ext_val(64'(prod_raw), 2 * DW, SGN));

  // Accumulator.
  logic [AW-1:0] acc_q, acc_d, acc_sum;

  assign acc_sum = AW'(add_clamp(64'(acc_q), 64'(prod_ext), AW, SGN, SAT));

  always_comb begin
    acc_d = acc_q;
    if (in_fire) acc_d = in_last ? '0 : acc_sum;
  end

  always_ff @(posedge clk) begin
    if (!rstn) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  // Drain slots: own result has priority; fwd only presented when own empty.
  logic          own_ld, own_pop, own_vld;
  logic [AW-1:0] own_dat;
  logic          fwd_ld, fwd_pop, fwd_vld;
  logic [AW-1:0] fwd_dat;

  assign own_ld       = in_fire & in_last;
  assign own_pop      = own_vld & res_rdy;
  assign fwd_pop      = ~own_vld & fwd_vld & res_rdy;
  assign drain_in_rdy = ~fwd_vld | fwd_pop;
  assign fwd_ld       = drain_in_vld & drain_in_rdy;

  pe_drain_slot #(.W(AW)) u_own (
    .clk      (clk),
    .rstn     (rstn),
    .ld_i     (own_ld),
    .ld_dat_i (acc_sum),
    .pop_i    (own_pop),
    .vld_o    (own_vld),
    .dat_o    (own_dat)
  );

  pe_drain_slot #(.W(AW)) u_fwd (
    .clk      (clk),
    .rstn     (rstn),
    .ld_i     (fwd_ld),
    .ld_dat_i (drain_in),
    .pop_i    (fwd_pop),
    .vld_o    (fwd_vld),
    .dat_o    (fwd_dat)
  );

  assign res_vld = own_vld | fwd_vld;
  assign res     = own_vld ? own_dat : fwd_dat;

  // Sticky overwrite flag: a new result lands on an undrained one. A
  // same-cycle handshake lets the old value leave, so no loss is reported.
  logic ovr_q, ovr_d;

  assign ovr_d = ovr_q | (own_ld & own_vld & ~res_rdy);

  always_ff @(posedge clk) begin
    if (!rstn) ovr_q <= 1'b0;
    else       ovr_q <= ovr_d;
  end

  assign ovr = ovr_q;

endmodule

// File: doc/pe_os_mac.md
# pe_os_mac

Parametrised output-stationary processing element for the systolic array: multiplies streamed activation/weight pairs into a local accumulator and forwards operands east/south one cycle later. On a `last`-tagged beat it closes the dot product and emits the result on a per-column drain chain with valid/ready handshake, so results leave the array while the next tile already accumulates. Drop-in successor to the fixed 8/32-bit PE; adds signed/unsigned mode, tile boundaries, result drain and overflow reporting.

## Interface
- `DW`, 8, operand width (activation and weight).
- `AW`, 32, accumulator/result width; must be ≥ 2*DW.
- `SIGNED`, 1, 1 = two's-complement operands, 0 = unsigned.
- `clk`  in  1  clock; all state updates on rising edge.
- `rstn`  in  1  reset, synchronous, active-low.
- `in_fire`  in  1  operand beat valid.
- `in_last`  in  1  final beat of current dot product; qualified by `in_fire`.
- `in_a`  in  DW  activation.
- `in_w`  in  DW  weight.
- `out_fire`, `out_last`  out  1  registered copies of `in_fire`, `in_last`.
- `out_a`, `out_w`  out  DW  registered operands to neighbours.
- `drain_in_vld`  in  1  upstream PE result valid.
- `drain_in`  in  AW  upstream PE result.
- `drain_in_rdy`  out  1  this PE accepts upstream result.
- `res_vld`  out  1  result valid toward downstream.
- `res`  out  AW  result toward downstream.
- `res_rdy`  in  1  downstream accepts result.
- `ovr`  out  1  sticky: own result overwritten before drained.

## Operation
- Product: full 2*DW product, sign-extended (`SIGNED`=1) or zero-extended to AW.
- Every cycle: `out_fire`<=`in_fire`, `out_last`<=`in_fire & in_last`. `out_a`/`out_w` load only when `in_fire`; otherwise hold.
- `in_fire & !in_last`: acc <= acc + prod.
- `in_fire & in_last`: own slot <= acc + prod, own_vld <= 1; acc <= 0.
- No `in_fire`: acc holds.
- Drain storage: own slot (own result) and fwd slot (one upstream result), both one-entry.
- Output priority: own slot first; fwd slot presented only when own slot empty. `res`/`res_vld` driven from selected slot; slot cleared on `res_vld & res_rdy`.
- `drain_in_rdy` = !fwd_vld | (fwd slot presented & `res_rdy`). Upstream transfer on `drain_in_vld & drain_in_rdy`.
- Own-slot collision: new `last` beat while own_vld=1 and not handshaken in same cycle -> new result overwrites, `ovr` <= 1 (clears only on reset). Handshake and new `last` in same cycle: old value leaves, new loads, no `ovr`.
- `res` holds stable while `res_vld & !res_rdy`.

## Timing
- Reset: all outputs 0 (`out_fire`, `out_last`, `out_a`, `out_w`, `res_vld`, `res`, `ovr`); `drain_in_rdy` = 1 after reset (fwd slot empty); acc = 0.
- Operand forward latency: 1 cycle.
- Accumulate: product of beat N visible in acc at cycle N+1.
- Result: `res_vld` high the cycle after the `last` beat; back-to-back tiles (next beat immediately after `last`) supported, next acc starts from 0.
- Pass-through: upstream result accepted at cycle T appears at `res` at T+1 earliest.
- Reset mid-tile or mid-drain: partial acc and both slots discarded, no `ovr`.

## Configuration
- `PE_SAT_EN` defined: accumulate and final add clamp to the AW-bit range (signed: −2^(AW−1)..2^(AW−1)−1; unsigned: 0..2^AW−1).
- Not defined: wrap modulo 2^AW.

## Structure
- Package `pe_pkg`: default DW/AW constants, extend-product function, saturating-add function (min/max per mode).
- Sub-module `pe_drain_slot`: one-entry valid/ready register with hold; instantiated for the fwd slot and reused for own slot.

## Test plan
- DW=8, SIGNED=1: beats (3,4),(−2,5),(7,−1)+last, `res_rdy`=1 -> `res`=−5, `res_vld` one cycle, acc 0 next.
- SIGNED=0: single beat (255,255)+last -> `res`=65025; signed build same inputs -> `res`=1.
- Drain order: own result 10 pending, upstream 20 offered, `res_rdy` low 3 cycles then high -> 10 then 20, `res` stable while stalled, `drain_in_rdy` low once fwd full.
- Collision: two tiles end 2 cycles apart with `res_rdy`=0 -> second value on `res`, `ovr`=1; repeat with `res_rdy`=1 on the second `last` cycle -> `ovr` stays 0.
- `PE_SAT_EN`, AW=16 signed: 3 beats (127,127)+last -> `res`=32767; without macro -> 48387 mod 2^16 as signed (−17149).
- `rstn` low mid-tile with fwd full -> next cycle all outputs 0, `drain_in_rdy`=1; following tile (1,1)+last -> `res`=1.
